// File: rtl/seven_seg_scan_ctrl_if.sv
// Purpose : bundles the display-load handshake and the scanned decoder/digit-select
//           outputs of seven_seg_scan_ctrl into one interface.
// Ports   : master = load source / display side, slave = scan controller.
//           load_valid/load_ready/load_data/load_dp/lz_blank_en feed the controller;
//           nibble_out/dp_out/digit_en drive the shared decoder and the digit commons.
interface seven_seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;
  logic [DIGITS-1:0]     load_dp;
  logic                  lz_blank_en;
  logic [3:0]            nibble_out;
  logic                  dp_out;
  logic [DIGITS-1:0]     digit_en;

  modport master (
    output load_valid, load_data, load_dp, lz_blank_en,
    input  load_ready, nibble_out, dp_out, digit_en
  );

  modport slave (
    input  load_valid, load_data, load_dp, lz_blank_en,
    output load_ready, nibble_out, dp_out, digit_en
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Purpose    : time-multiplexes DIGITS BCD digits onto one shared 7-segment decoder,
//              with a blanking gap per slot and frame-aligned display updates.
// Latency    : all outputs registered; a load becomes visible at the first frame
//              boundary after it leaves the pending buffer (digit 0 BLANK slot).
// Backpressure: load_ready = ~pending_full (registered); a source offered while
//              ready is low must hold valid/data until accepted.
// Ports      : clk, rst_n (async active-low) plus bus (slave modport): load_valid,
//              load_ready, load_data, load_dp, lz_blank_en in/out of the handshake;
//              nibble_out, dp_out, digit_en towards the decoder and digit commons.
module seven_seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  bus
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Scan state
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;

  // Double-buffered display data: active drives the scan, pending holds the next word
  logic [4*DIGITS-1:0]  act_dat_q, act_dat_d;
  logic [DIGITS-1:0]    act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0]  pend_dat_q, pend_dat_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic                 pend_full_q, pend_full_d;

  // Registered outputs
  logic                 load_ready_q, load_ready_d;
  logic [3:0]           nibble_q, nibble_d;
  logic                 dp_q, dp_d;
  logic [DIGITS-1:0]    digit_en_q, digit_en_d;

  // Combinational helpers
  logic                 slot_end;
  logic                 frame_end;
  logic                 load_acc;
  logic                 zero_run;
  logic [DIGITS-1:0]    lz_vec;
  logic [DIGITS-1:0]    one_hot;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    act_dat_d   = act_dat_q;
    act_dp_d    = act_dp_q;
    pend_dat_d  = pend_dat_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;

    slot_end  = (state_q == ST_SHOW) && (cnt_q == CW'(SLOT_CYC - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    load_acc  = bus.load_valid && load_ready_q;

    // Slot sequencing: cnt runs across the whole slot, BLANK occupies its first
    // BLANK_CYC cycles, SHOW the remainder.
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYC - 1)) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (slot_end) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Pending -> active only on the frame boundary so a frame never mixes words.
    if (frame_end && pend_full_q) begin
      act_dat_d   = pend_dat_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end

    // Acceptance implies pending was empty, so it can never collide with the
    // transfer above; a load on a boundary edge simply waits for the next one.
    if (load_acc) begin
      pend_dat_d  = bus.load_data;
      pend_dp_d   = bus.load_dp;
      pend_full_d = 1'b1;
    end

    load_ready_d = ~pend_full_d;

    // Leading-zero mask: walk from the top digit down while everything seen so
    // far is zero. Digit 0 is never masked.
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run  = zero_run && (act_dat_d[4*i +: 4] == 4'h0);
      lz_vec[i] = bus.lz_blank_en && zero_run;
    end

    one_hot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;

    // Outputs follow the next-state slot so they line up with state/cnt/idx.
    // Nibble and dp are presented during BLANK too, giving the decoder time to settle.
    nibble_d   = act_dat_d[4*int'(idx_d) +: 4];
    dp_d       = act_dp_d[idx_d];
    digit_en_d = '0;
    if (state_d == ST_SHOW) begin
      if (lz_vec[idx_d]) begin
        dp_d = 1'b0;
      end else begin
        digit_en_d = one_hot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_dat_q    <= '0;
      act_dp_q     <= '0;
      pend_dat_q   <= '0;
      pend_dp_q    <= '0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      nibble_q     <= 4'h0;
      dp_q         <= 1'b0;
      digit_en_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_dat_q    <= act_dat_d;
      act_dp_q     <= act_dp_d;
      pend_dat_q   <= pend_dat_d;
      pend_dp_q    <= pend_dp_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= load_ready_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.nibble_out = nibble_q;
  assign bus.dp_out     = dp_q;
  assign bus.digit_en   = digit_en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Purpose : self-checking bench for seven_seg_scan_ctrl (DIGITS=4, SLOT_CYC=8, BLANK_CYC=2).
// Timing  : inputs driven and outputs sampled on the falling edge; cycle 0 is the
//           interval between reset release and the first rising edge.
// Model   : slot/digit position derived from the cycle count since reset, data
//           buffers modelled as plain active/pending words.
module tb_seven_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * SLOT;

  logic clk;
  logic rst_n;

  seven_seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus();

  seven_seg_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SLOT_CYC (SLOT),
    .BLANK_CYC(BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int t;

  // Reference model state
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  logic        m_pfull;
  logic        m_lz;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [3:0] nib;
    logic       dp;
    logic       rdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_act   = '0;
    m_adp   = '0;
    m_pend  = '0;
    m_pdp   = '0;
    m_pfull = 1'b0;
    m_lz    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.load_dp     = '0;
    bus.lz_blank_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Check this cycle's outputs against the model, drive this cycle's inputs,
  // advance the model across the rising edge, then move to the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] dp,
                       input logic lz, output logic acc);
    int pos, idx, c;
    logic show, blk;
    logic [3:0] exp_en;
    logic exp_dp;
    pos    = t % FRAME;
    idx    = pos / SLOT;
    c      = pos % SLOT;
    show   = (c >= BLANK);
    blk    = m_lz && (idx > 0) && ((m_act >> (4*idx)) == 16'h0);
    exp_en = (show && !blk) ? (4'b0001 << idx) : 4'b0000;
    exp_dp = (show && blk) ? 1'b0 : m_adp[idx];
    chk("digit_en",   32'(bus.digit_en),   32'(exp_en));
    chk("nibble_out", 32'(bus.nibble_out), 32'(m_act[4*idx +: 4]));
    chk("dp_out",     32'(bus.dp_out),     32'(exp_dp));
    chk("load_ready", 32'(bus.load_ready), 32'(!m_pfull));

    bus.load_valid  = v;
    bus.load_data   = d;
    bus.load_dp     = dp;
    bus.lz_blank_en = lz;

    acc = v && !m_pfull;
    if ((pos == FRAME - 1) && m_pfull) begin
      m_act   = m_pend;
      m_adp   = m_pdp;
      m_pfull = 1'b0;
    end
    if (acc) begin
      m_pend  = d;
      m_pdp   = dp;
      m_pfull = 1'b1;
    end
    m_lz = lz;
    t++;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[12];
    logic acc;
    logic src_v;
    logic [15:0] src_d;
    logic [3:0] src_dp;
    logic lz_r;
    int acc_t;
    int hi_cnt, one_cnt;

    n_chk  = 0;
    n_fail = 0;

    // Mid-frame load of 0x1234 / dp 0010 at cycle 5.
    tbl[0]  = '{cyc:0,  en:4'b0000, nib:4'h0, dp:1'b0, rdy:1'b1};
    tbl[1]  = '{cyc:2,  en:4'b0001, nib:4'h0, dp:1'b0, rdy:1'b1};
    tbl[2]  = '{cyc:6,  en:4'b0001, nib:4'h0, dp:1'b0, rdy:1'b0};
    tbl[3]  = '{cyc:10, en:4'b0010, nib:4'h0, dp:1'b0, rdy:1'b0};
    tbl[4]  = '{cyc:26, en:4'b1000, nib:4'h0, dp:1'b0, rdy:1'b0};
    tbl[5]  = '{cyc:31, en:4'b1000, nib:4'h0, dp:1'b0, rdy:1'b0};
    tbl[6]  = '{cyc:32, en:4'b0000, nib:4'h4, dp:1'b0, rdy:1'b1};
    tbl[7]  = '{cyc:34, en:4'b0001, nib:4'h4, dp:1'b0, rdy:1'b1};
    tbl[8]  = '{cyc:42, en:4'b0010, nib:4'h3, dp:1'b1, rdy:1'b1};
    tbl[9]  = '{cyc:50, en:4'b0100, nib:4'h2, dp:1'b0, rdy:1'b1};
    tbl[10] = '{cyc:58, en:4'b1000, nib:4'h1, dp:1'b0, rdy:1'b1};
    tbl[11] = '{cyc:66, en:4'b0001, nib:4'h4, dp:1'b0, rdy:1'b1};

    // ---- Table-driven run (also covers reset / no-load scan for frame 0) ----
    do_reset();
    for (int k = 0; k < 12; k++) begin
      while (t < tbl[k].cyc) cycle(t == 5, 16'h1234, 4'b0010, 1'b0, acc);
      chk("tbl_en",  32'(bus.digit_en),   32'(tbl[k].en));
      chk("tbl_nib", 32'(bus.nibble_out), 32'(tbl[k].nib));
      chk("tbl_dp",  32'(bus.dp_out),     32'(tbl[k].dp));
      chk("tbl_rdy", 32'(bus.load_ready), 32'(tbl[k].rdy));
    end

    // ---- Second load while pending is full ----
    do_reset();
    src_v = 1'b0;
    acc_t = -1;
    while (t < 80) begin
      if (t == 3) cycle(1'b1, 16'h9876, 4'b0000, 1'b0, acc);
      else begin
        if (t == 10) begin src_v = 1'b1; src_d = 16'h0421; src_dp = 4'b0100; end
        if (t == 20) chk("held_rdy_low", 32'(bus.load_ready), 32'd0);
        if (t == 35) chk("first_word", 32'(bus.nibble_out), 32'h6);
        if (t == 67) chk("second_word", 32'(bus.nibble_out), 32'h1);
        cycle(src_v, src_d, src_dp, 1'b0, acc);
        if (acc && src_v) begin acc_t = t - 1; src_v = 1'b0; end
      end
    end
    chk("held_accept_cyc", 32'(acc_t), 32'd32);

    // ---- Leading-zero blanking: 0x0000 frame then 0x0050 frame ----
    do_reset();
    hi_cnt  = 0;
    one_cnt = 0;
    while (t < 64) begin
      if (t >= 1 && t < 32 && (bus.digit_en[3:1] != 3'b000)) hi_cnt++;
      if (t >= 32 && (bus.digit_en[3] || bus.digit_en[2])) hi_cnt++;
      if (t >= 32 && bus.digit_en[1]) one_cnt++;
      if (t == 42) chk("lz_idx1_nib", 32'(bus.nibble_out), 32'h5);
      if (t == 34) chk("lz_idx0", 32'({bus.digit_en, bus.nibble_out}), 32'h10);
      cycle(t == 0, 16'h0050, 4'b0000, 1'b1, acc);
    end
    chk("lz_upper_never_on", 32'(hi_cnt), 32'd0);
    chk("lz_idx1_show_cyc", 32'(one_cnt), 32'(SLOT - BLANK));

    // ---- Load accepted on a frame-boundary edge ----
    do_reset();
    while (t < 100) begin
      if (t == 60) chk("bnd_cur_old", 32'(bus.nibble_out), 32'h4);
      if (t == 64) chk("bnd_rdy_low", 32'(bus.load_ready), 32'd0);
      if (t == 66) chk("bnd_next_old", 32'(bus.nibble_out), 32'h1);
      if (t == 98) chk("bnd_new", 32'(bus.nibble_out), 32'h5);
      if (t == 0)       cycle(1'b1, 16'h4321, 4'b0000, 1'b0, acc);
      else if (t == 63) cycle(1'b1, 16'h8765, 4'b0001, 1'b0, acc);
      else              cycle(1'b0, 16'h0000, 4'b0000, 1'b0, acc);
    end

    // ---- Async reset during SHOW of idx 2 ----
    do_reset();
    while (t < 52) begin
      if (t == 0)       cycle(1'b1, 16'h7777, 4'b1111, 1'b0, acc);
      else if (t == 40) cycle(1'b1, 16'h3333, 4'b0000, 1'b0, acc);
      else              cycle(1'b0, 16'h0000, 4'b0000, 1'b0, acc);
    end
    chk("pre_rst_en", 32'(bus.digit_en), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en",  32'(bus.digit_en),   32'h0);
    chk("arst_nib", 32'(bus.nibble_out), 32'h0);
    chk("arst_rdy", 32'(bus.load_ready), 32'h1);
    chk("arst_dp",  32'(bus.dp_out),     32'h0);
    do_reset();
    while (t < 40) cycle(1'b0, 16'h0000, 4'b0000, 1'b0, acc);

    // ---- Randomised run against the model ----
    do_reset();
    src_v = 1'b0;
    lz_r  = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!src_v && ($urandom_range(0, 9) == 0)) begin
        src_v  = 1'b1;
        src_d  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        src_dp = 4'($urandom);
      end
      if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
      cycle(src_v, src_d, src_dp, lz_r, acc);
      if (acc) src_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexes DIGITS BCD digits onto one shared 7-segment decoder (the existing `sd` block) and one common segment bus.
- Each cycle it presents one nibble (w,x,y,z) plus a decimal point to the decoder and drives a one-hot digit enable.
- A blanking gap between digits suppresses ghosting.
- New display values arrive through a valid/ready load port and take effect only at frame boundaries, so a frame never mixes old and new data.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- SLOT_CYC, 1000, clock cycles per digit slot (blank + show).
- BLANK_CYC, 16, cycles at the start of each slot with all digits disabled; 1 <= BLANK_CYC < SLOT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  new display word offered.
- load_ready  out  1  pending buffer empty, load accepted when valid&ready.
- load_data  in  4*DIGITS  BCD digits, digit i at [4i+3:4i]; digit 0 is least significant.
- load_dp  in  DIGITS  decimal-point bits, bit i for digit i.
- lz_blank_en  in  1  leading-zero blanking enable, sampled every cycle.
- nibble_out  out  4  to decoder {w,x,y,z}, w = MSB.
- dp_out  out  1  to decoder dp.
- digit_en  out  DIGITS  one-hot active-high digit select; all zero during blank.

Behaviour:
- Reset (async assert, sync release): state=BLANK, idx=0, cnt=0, active/pending data=0, pending_full=0, digit_en=0, nibble_out=0, dp_out=0, load_ready=1.
- FSM has two states, BLANK and SHOW, and a slot counter cnt in the range 0..SLOT_CYC-1.
  - BLANK: digit_en=0. nibble_out and dp_out already show digit idx, so the decoder settles early.
  - BLANK -> SHOW when cnt==BLANK_CYC-1.
  - SHOW: digit_en = one-hot(idx), unless idx is blanked.
  - SHOW -> BLANK when cnt==SLOT_CYC-1. At that point cnt=0 and idx advances by 1, wrapping from DIGITS-1 to 0.
- Frame boundary is the SHOW->BLANK transition with idx==DIGITS-1.
  - If pending_full, active<=pending and pending_full<=0 on that edge.
  - The new active data is first displayed in digit 0's BLANK slot.
- Load handshake:
  - load_ready = ~pending_full, registered.
  - Accept on valid&ready: pending<=data/dp, pending_full<=1, load_ready falls the next cycle.
  - A load accepted on the same edge as a frame boundary with pending empty is captured in pending and transfers at the next boundary.
  - A load offered while ready=0 is ignored; the source must hold it.
- Leading-zero blanking:
  - Digit i is blanked when lz_blank_en=1, i>0, and active digits i..DIGITS-1 are all 0.
  - A blanked digit keeps digit_en=0 and dp_out=0 during SHOW.
  - Digit 0 is never blanked.
- Non-BCD nibbles (A-F) pass through unchanged; the decoder defines their glyph.
- All outputs are registered. One frame lasts DIGITS*SLOT_CYC cycles.
- Reset mid-frame returns everything to reset values immediately; no partial digit stays enabled.

Test Plan (DIGITS=4, SLOT_CYC=8, BLANK_CYC=2):
- Reset, no load:
  - digit_en=0 for cycles 0-1, then 0001 for cycles 2-7, 0010 for cycles 10-15, 0100 for 18-23, 1000 for 26-31.
  - Pattern repeats with period 32; nibble_out=0.
- Load 0x1234, dp=0010 at cycle 5 (mid-frame):
  - load_ready drops at cycle 6.
  - Digits keep showing 0 until the boundary at cycle 31.
  - From cycle 32: nibble 4,3,2,1 at idx 0..3; dp_out=1 only during idx 1 SHOW.
  - load_ready returns to 1 at cycle 32.
- Second load while pending_full=1:
  - load_ready=0, so the transfer is not accepted.
  - After the boundary, ready rises, the held load is accepted, and it appears one frame later.
- lz_blank_en=1 with data 0x0050:
  - digit_en never asserts for idx 2 or 3.
  - idx 1 shows 5 and idx 0 shows 0.
  - With data 0x0000, only idx 0 enables.
- Load accepted on a boundary edge:
  - The value goes to pending; the current frame shows old data, the next frame keeps old data, and the following frame shows the new value.
- Assert rst_n=0 during a SHOW cycle of idx 2:
  - digit_en=0, nibble_out=0, and load_ready=1 asynchronously.
  - After release, scanning restarts at idx 0 in BLANK.
